// File: rtl/sdram_job_sched.sv
// sdram_job_sched: two-requester round-robin job scheduler driving the sdram_peri CSR bus.
// Ports: clk_i/rst_i (async active-high); per-requester job inputs (req/rw/addr/len/wdata),
//   client handshakes (wd_ack/rd_valid/rdata/gnt/done/err); CSR bus adr/we/dat_w/dat_r.
module sdram_job_sched #(
  parameter logic [4:0] CSR_BANK     = 5'd1,
  parameter int         RD_LAT       = 1,
  parameter int         POLL_TIMEOUT = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  rw_i,
  input  logic [63:0] job_addr_i,
  input  logic [7:0]  job_len_i,
  input  logic [63:0] wdata_i,
  output logic [1:0]  wd_ack_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rd_valid_o,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [1:0]  err_o,
  output logic [13:0] adr_o,
  output logic        we_o,
  output logic [7:0]  dat_w_o,
  input  logic [7:0]  dat_r_i
);

  localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int POLL_W = $clog2(POLL_TIMEOUT + 1);

  localparam logic [8:0] REG_STATUS = 9'd0;
  localparam logic [8:0] REG_ADR0   = 9'd1;
  localparam logic [8:0] REG_DAT0   = 9'd5;
  localparam logic [8:0] REG_IDX    = 9'd9;
  localparam logic [8:0] REG_LEN    = 9'd10;
  localparam logic [8:0] REG_CMD    = 9'd11;

  typedef enum logic [3:0] {
    S_IDLE, S_GRANT, S_SET_LEN, S_SET_ADR, S_W_IDX, S_W_DAT, S_START,
    S_POLL_ADR, S_POLL_WAIT, S_R_IDX, S_R_ADR, S_R_WAIT, S_R_VLD, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;     // requester being served
  logic                last_q, last_d;   // requester served last (round-robin pointer)
  logic                rw_q, rw_d;
  logic [3:0]          len_q, len_d;
  logic [31:0]         addr_q, addr_d;
  logic [1:0]          byte_q, byte_d;
  logic [2:0]          word_q, word_d;
  logic [LAT_W-1:0]    wait_q, wait_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                last_word;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;   // so a simultaneous request after reset picks requester 0
      rw_q    <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      wait_q  <= '0;
      poll_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      wait_q  <= wait_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign last_word = ({1'b0, word_q} == (len_q - 4'd1));
  assign rdata_o   = rdata_q;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    rw_d       = rw_q;
    len_d      = len_q;
    addr_d     = addr_q;
    byte_d     = byte_q;
    word_d     = word_q;
    wait_d     = wait_q;
    poll_d     = poll_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    adr_o      = '0;
    we_o       = 1'b0;
    dat_w_o    = '0;
    wd_ack_o   = '0;
    rd_valid_o = '0;
    done_o     = '0;
    err_o      = '0;
    gnt_o      = '0;

    // Grant covers every cycle of the job except the done cycle.
    if (state_q != S_IDLE && state_q != S_DONE) gnt_o[sel_q] = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          sel_d   = (req_i == 2'b11) ? ~last_q : req_i[1];
          rw_d    = rw_i[sel_d];
          len_d   = job_len_i[{sel_d, 2'b00} +: 4];
          addr_d  = job_addr_i[{sel_d, 5'b00000} +: 32];
          byte_d  = '0;
          word_d  = '0;
          poll_d  = '0;
          err_d   = 1'b0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (len_q == 4'd0 || len_q > 4'd8) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SET_LEN;
        end
      end
      S_SET_LEN: begin
        adr_o   = {CSR_BANK, REG_LEN};
        we_o    = 1'b1;
        dat_w_o = {4'd0, len_q};
        byte_d  = '0;
        state_d = S_SET_ADR;
      end
      S_SET_ADR: begin
        adr_o   = {CSR_BANK, REG_ADR0 + {7'd0, byte_q}};
        we_o    = 1'b1;
        dat_w_o = addr_q[{byte_q, 3'b000} +: 8];
        byte_d  = byte_q + 2'd1;
        if (byte_q == 2'd3) state_d = rw_q ? S_START : S_W_IDX;
      end
      S_W_IDX: begin
        adr_o   = {CSR_BANK, REG_IDX};
        we_o    = 1'b1;
        dat_w_o = {5'd0, word_q};
        byte_d  = '0;
        state_d = S_W_DAT;
      end
      S_W_DAT: begin
        // wdata is used live: the client holds word k until its ack.
        adr_o   = {CSR_BANK, REG_DAT0 + {7'd0, byte_q}};
        we_o    = 1'b1;
        dat_w_o = wdata_i[{sel_q, byte_q, 3'b000} +: 8];
        byte_d  = byte_q + 2'd1;
        if (byte_q == 2'd3) begin
          wd_ack_o[sel_q] = 1'b1;
          if (last_word) begin
            state_d = S_START;
          end else begin
            word_d  = word_q + 3'd1;
            state_d = S_W_IDX;
          end
        end
      end
      S_START: begin
        adr_o   = {CSR_BANK, REG_CMD};
        we_o    = 1'b1;
        dat_w_o = {7'd0, rw_q};
        poll_d  = '0;
        state_d = S_POLL_ADR;
      end
      S_POLL_ADR: begin
        adr_o   = {CSR_BANK, REG_STATUS};
        wait_d  = LAT_W'(RD_LAT - 1);
        state_d = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else if (dat_r_i[0]) begin
          if (poll_q == POLL_W'(POLL_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            poll_d  = poll_q + 1'b1;
            state_d = S_POLL_ADR;
          end
        end else begin
          word_d  = '0;
          state_d = rw_q ? S_R_IDX : S_DONE;
        end
      end
      S_R_IDX: begin
        adr_o   = {CSR_BANK, REG_IDX};
        we_o    = 1'b1;
        dat_w_o = {5'd0, word_q};
        byte_d  = '0;
        state_d = S_R_ADR;
      end
      S_R_ADR: begin
        adr_o   = {CSR_BANK, REG_DAT0 + {7'd0, byte_q}};
        wait_d  = LAT_W'(RD_LAT - 1);
        state_d = S_R_WAIT;
      end
      S_R_WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else begin
          rdata_d[{byte_q, 3'b000} +: 8] = dat_r_i;
          byte_d  = byte_q + 2'd1;
          state_d = (byte_q == 2'd3) ? S_R_VLD : S_R_ADR;
        end
      end
      S_R_VLD: begin
        rd_valid_o[sel_q] = 1'b1;
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          word_d  = word_q + 3'd1;
          state_d = S_R_IDX;
        end
      end
      S_DONE: begin
        done_o[sel_q] = 1'b1;
        err_o[sel_q]  = err_q;
        last_d        = sel_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_job_sched.sv
// Scoreboard bench for sdram_job_sched: directed jobs push expected bus/handshake events,
// a negedge monitor pops and compares them; a CSR slave model answers STATUS and data reads.
module tb_sdram_job_sched;

  logic        clk, rst_i;
  logic [1:0]  req_i, rw_i;
  logic [63:0] job_addr_i, wdata_i;
  logic [7:0]  job_len_i;
  logic [1:0]  wd_ack_o, rd_valid_o, gnt_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic [13:0] adr_o;
  logic        we_o;
  logic [7:0]  dat_w_o, dat_r_i;

  sdram_job_sched dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .rw_i(rw_i),
    .job_addr_i(job_addr_i), .job_len_i(job_len_i), .wdata_i(wdata_i),
    .wd_ack_o(wd_ack_o), .rdata_o(rdata_o), .rd_valid_o(rd_valid_o),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .adr_o(adr_o), .we_o(we_o), .dat_w_o(dat_w_o), .dat_r_i(dat_r_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [1:0] K_WR = 2'd1, K_RDV = 2'd2, K_DN = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [13:0] adr;
    logic [7:0]  dat;
    logic [1:0]  bits;
    logic [31:0] rd;
    logic [1:0]  misc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // CSR slave model state
  int          poll_cnt = 0;
  int          busy_left = 0;
  bit          stuck = 0;
  logic [31:0] rd_word = 32'h0;

  // write-data client state
  logic [31:0] ww0[2];
  logic [31:0] ww1[2];
  int          widx[2];

  function automatic void push_wr(input logic [8:0] rg, input logic [7:0] d, input logic [1:0] ack);
    ev_t e;
    e = '0; e.kind = K_WR; e.adr = {5'd1, rg}; e.dat = d; e.bits = ack;
    exp_q.push_back(e);
  endfunction

  function automatic void push_rdv(input logic [1:0] v, input logic [31:0] w);
    ev_t e;
    e = '0; e.kind = K_RDV; e.bits = v; e.rd = w;
    exp_q.push_back(e);
  endfunction

  function automatic void push_done(input int idx, input logic e_bit);
    ev_t e;
    e = '0; e.kind = K_DN; e.bits = 2'b01 << idx; e.dat = e_bit ? {6'd0, 2'b01 << idx} : 8'd0;
    exp_q.push_back(e);   // misc (gnt) expected 0 in the done cycle
  endfunction

  // Generic expected sequence for legal jobs of 1..2 words.
  function automatic void push_job(input int idx, input logic rwb, input logic [31:0] addr,
                                   input logic [3:0] len, input logic [31:0] w0, input logic [31:0] w1,
                                   input logic [31:0] rdw, input logic jerr);
    logic [31:0] w;
    push_wr(9'd10, {4'd0, len}, 2'b00);
    for (int b = 0; b < 4; b++) push_wr(9'(1 + b), 8'(addr >> (8 * b)), 2'b00);
    if (!rwb) begin
      for (int k = 0; k < int'(len); k++) begin
        w = (k == 0) ? w0 : w1;
        push_wr(9'd9, 8'(k), 2'b00);
        for (int b = 0; b < 4; b++)
          push_wr(9'(5 + b), 8'(w >> (8 * b)), (b == 3) ? (2'b01 << idx) : 2'b00);
      end
    end
    push_wr(9'd11, {7'd0, rwb}, 2'b00);
    if (rwb && !jerr) begin
      for (int k = 0; k < int'(len); k++) begin
        push_wr(9'd9, 8'(k), 2'b00);
        push_rdv(2'b01 << idx, rdw);
      end
    end
    push_done(idx, jerr);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // CSR slave: STATUS busy model and data-register reads, one cycle latency.
  always @(posedge clk) begin
    if (!we_o && adr_o == 14'h200) begin
      poll_cnt = poll_cnt + 1;
      dat_r_i <= (stuck || busy_left > 0) ? 8'h01 : 8'h00;
      if (busy_left > 0) busy_left = busy_left - 1;
    end else if (!we_o && adr_o[13:9] == 5'd1 && adr_o[8:0] >= 9'd5 && adr_o[8:0] <= 9'd8) begin
      dat_r_i <= 8'(rd_word >> (8 * (int'(adr_o[8:0]) - 5)));
    end else begin
      dat_r_i <= 8'h00;
    end
  end

  // Write-data client: advance to the next word the cycle after wd_ack.
  initial begin
    logic [1:0] a;
    forever begin
      @(negedge clk);
      a = wd_ack_o;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (a[i]) widx[i] = widx[i] + 1;
        wdata_i[i*32 +: 32] = (widx[i] == 0) ? ww0[i] : ww1[i];
      end
    end
  end

  // Monitor: every bus write, rd_valid and done is checked against the scoreboard.
  always @(negedge clk) begin
    ev_t obs, e;
    if (!rst_i && (we_o || (|rd_valid_o) || (|done_o))) begin
      obs = '0;
      if (we_o) begin
        obs.kind = K_WR; obs.adr = adr_o; obs.dat = dat_w_o; obs.bits = wd_ack_o;
      end else if (|rd_valid_o) begin
        obs.kind = K_RDV; obs.bits = rd_valid_o; obs.rd = rdata_o;
      end else begin
        obs.kind = K_DN; obs.bits = done_o; obs.dat = {6'd0, err_o}; obs.misc = gnt_o;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %h expected none", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL scoreboard: got %h expected %h", obs, e);
        end
      end
    end
  end

  task automatic run_job(input int idx, input logic rwb, input logic [31:0] addr, input logic [3:0] len,
                         input logic [31:0] w0, input logic [31:0] w1, input int budget);
    bit got;
    bit legal;
    legal = (len != 4'd0) && (len <= 4'd8);
    @(posedge clk); #1;
    rw_i[idx] = rwb;
    job_addr_i[idx*32 +: 32] = addr;
    job_len_i[idx*4 +: 4] = len;
    ww0[idx] = w0; ww1[idx] = w1; widx[idx] = 0;
    wdata_i[idx*32 +: 32] = w0;
    poll_cnt = 0;
    req_i[idx] = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (gnt_o[idx]) got = 1;
    end
    chk("gnt_onehot", {62'd0, gnt_o}, {62'd0, 2'b01 << idx});
    req_i[idx] = 1'b0;
    @(negedge clk);
    if (legal) begin
      chk("first_we_latency", {49'd0, we_o, adr_o}, {49'd0, 1'b1, 14'h20a});
      got = 0;
      for (int c = 0; c < budget && !got; c++) begin
        @(negedge clk);
        if (|done_o) got = 1;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
      end
    end else begin
      chk("bad_len_done_err", {60'd0, done_o, err_o}, {60'd0, 2'b01 << idx, 2'b01 << idx});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int ndone;
    bit got;
    rst_i = 1'b1; req_i = '0; rw_i = '0; job_addr_i = '0; job_len_i = '0; wdata_i = '0;
    ww0[0] = '0; ww0[1] = '0; ww1[0] = '0; ww1[1] = '0; widx[0] = 0; widx[1] = 0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {gnt_o, adr_o, we_o, dat_w_o, wd_ack_o, rd_valid_o, done_o, err_o},
        '0);
    chk("rst_rdata", {32'd0, rdata_o}, 64'd0);
    rst_i = 1'b0;

    // Both requesting continuously: 0,1,0,1 with bad-length (err) jobs.
    push_done(0, 1); push_done(1, 1); push_done(0, 1); push_done(1, 1);
    @(posedge clk); #1;
    job_len_i = 8'h00;
    req_i = 2'b11;
    ndone = 0;
    for (int c = 0; c < 60 && ndone < 4; c++) begin
      @(negedge clk);
      if (|done_o) ndone++;
    end
    req_i = 2'b00;
    chk("arb_done_count", 64'(ndone), 64'd4);

    // Write job, requester 0, hand-computed CSR sequence.
    push_wr(9'd10, 8'h02, 2'b00);
    push_wr(9'd1, 8'h03, 2'b00); push_wr(9'd2, 8'h02, 2'b00);
    push_wr(9'd3, 8'h01, 2'b00); push_wr(9'd4, 8'h00, 2'b00);
    push_wr(9'd9, 8'h00, 2'b00);
    push_wr(9'd5, 8'h22, 2'b00); push_wr(9'd6, 8'h11, 2'b00);
    push_wr(9'd7, 8'h00, 2'b00); push_wr(9'd8, 8'h00, 2'b01);
    push_wr(9'd9, 8'h01, 2'b00);
    push_wr(9'd5, 8'h33, 2'b00); push_wr(9'd6, 8'h22, 2'b00);
    push_wr(9'd7, 8'h00, 2'b00); push_wr(9'd8, 8'h00, 2'b01);
    push_wr(9'd11, 8'h00, 2'b00);
    push_done(0, 0);
    busy_left = 0;
    run_job(0, 1'b0, 32'h00010203, 4'd2, 32'h1122, 32'h2233, 200);
    chk("write_polls", 64'(poll_cnt), 64'd1);
    chk("write_acks_seen", 64'(widx[0]), 64'd2);

    // Read job, requester 1, STATUS busy for 3 polls.
    push_wr(9'd10, 8'h01, 2'b00);
    push_wr(9'd1, 8'h10, 2'b00); push_wr(9'd2, 8'h20, 2'b00);
    push_wr(9'd3, 8'h40, 2'b00); push_wr(9'd4, 8'h80, 2'b00);
    push_wr(9'd11, 8'h01, 2'b00);
    push_wr(9'd9, 8'h00, 2'b00);
    push_rdv(2'b10, 32'h44556677);
    push_done(1, 0);
    rd_word = 32'h44556677;
    busy_left = 3;
    run_job(1, 1'b1, 32'h80402010, 4'd1, 32'h0, 32'h0, 200);
    chk("read_polls", 64'(poll_cnt), 64'd4);
    chk("read_rdata_hold", {32'd0, rdata_o}, {32'd0, 32'h44556677});

    // Zero length on requester 0: immediate done+err, no bus writes.
    push_done(0, 1);
    run_job(0, 1'b0, 32'h12345678, 4'd0, 32'h0, 32'h0, 20);
    // Length 9 on requester 1: also rejected.
    push_done(1, 1);
    run_job(1, 1'b1, 32'h12345678, 4'd9, 32'h0, 32'h0, 20);

    // STATUS stuck busy: abort after exactly 4096 polls.
    stuck = 1;
    push_job(0, 1'b0, 32'hCAFEF00D, 4'd1, 32'hA5B6C7D8, 32'h0, 32'h0, 1'b1);
    run_job(0, 1'b0, 32'hCAFEF00D, 4'd1, 32'hA5B6C7D8, 32'h0, 20000);
    chk("timeout_polls", 64'(poll_cnt), 64'd4096);
    stuck = 0;
    push_job(1, 1'b0, 32'h01020304, 4'd1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
    run_job(1, 1'b0, 32'h01020304, 4'd1, 32'hDEADBEEF, 32'h0, 200);
    chk("after_timeout_polls", 64'(poll_cnt), 64'd1);

    // Reset during the address phase: outputs clear at once, no done, queue flushed.
    push_wr(9'd10, 8'h01, 2'b00);
    push_wr(9'd1, 8'h88, 2'b00);
    @(posedge clk); #1;
    rw_i[0] = 1'b0; job_addr_i[31:0] = 32'h55667788; job_len_i[3:0] = 4'd1;
    ww0[0] = 32'h0; widx[0] = 0; req_i[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (we_o && adr_o == 14'h201) got = 1;
    end
    chk("reach_addr_phase", 64'(got), 64'd1);
    req_i[0] = 1'b0;
    #2 rst_i = 1'b1;
    #1 chk("rst_async_clear", {45'd0, gnt_o, adr_o, we_o, dat_w_o}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", {62'd0, done_o}, 64'd0);
    end
    rst_i = 1'b0;
    chk("rst_flush", 64'(exp_q.size()), 64'd0);
    push_job(1, 1'b1, 32'h0A0B0C0D, 4'd1, 32'h0, 32'h0, 32'h89ABCDEF, 1'b0);
    rd_word = 32'h89ABCDEF;
    busy_left = 0;
    run_job(1, 1'b1, 32'h0A0B0C0D, 4'd1, 32'h0, 32'h0, 200);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
